spi_bus_bridge: RTL
===================

# spi_bus_bridge

Parametrised SPI-mode-0 slave that turns SPI frames into parallel-bus read and write cycles. Successor to `spi_ctl`, with these additions:
- configurable address and data widths;
- system-clock-synchronous operation;
- a defined read-latency window;
- error reporting;
- optional auto-increment bursts.

It sits between the board SPI pins and the CPLD peripheral bus, replacing `spi_ctl`.

## Interface
- `ADDR_W`, 7: address width; the header is `ADDR_W+1` bits, MSB first (`rw`, then address).
- `DATA_W`, 8: data-word width, ≥ 4.
- `RD_LAT`, 1: clk cycles from `read_n` low to `rdata` valid (1..4).

Ports:
- `clk`  in  1  system clock; must run ≥ 16× `sck` frequency.
- `reset`  in  1  asynchronous, active-high reset.
- `nss`  in  1  SPI slave select, active-low, asynchronous to `clk`.
- `sck`  in  1  SPI clock, CPOL=0, asynchronous to `clk`.
- `mosi`  in  1  SPI data in.
- `miso`  out  1  SPI data out.
- `miso_oe`  out  1  enable for the external `miso` tri-state buffer.
- `address_bus`  out  `ADDR_W`  bus address.
- `wdata`  out  `DATA_W`  bus write data.
- `rdata`  in  `DATA_W`  bus read data.
- `read_n`  out  1  read strobe, active-low, 1 clk wide.
- `write_n`  out  1  write strobe, active-low, 1 clk wide.
- `busy`  out  1  high while `nss` is low and the frame is accepted.
- `frame_err`  out  1  1-clk pulse on a malformed frame.

## Operation

**Synchronisation.** `nss`, `sck` and `mosi` each pass through a 2-FF synchroniser; edges are detected on the synchronised copies.
- Sample `mosi` on `sck` rising edges.
- Update `miso` on `sck` falling edges.
- All shift registers are MSB first.

**States.** IDLE, HDR, RD_WAIT, DATA, HOLD, LOCK.
- IDLE: a falling edge on `nss` → HDR; bit counter cleared; `busy`=1.
- HDR: shift `ADDR_W+1` bits. On the last rising edge, latch `rw` and `address_bus`.
  - `rw`=1: assert `read_n` for 1 clk, go to RD_WAIT.
  - `rw`=0: go to DATA.
- RD_WAIT: after `RD_LAT` clks, load `rdata` into the TX shifter → DATA. The shifter MSB reaches `miso` at the next `sck` falling edge.
- DATA: shift `DATA_W` bits. On the last rising edge:
  - write frame: copy the RX shifter to `wdata`, assert `write_n` for 1 clk.
  - read frame: the word is complete.
  - then go to HOLD (burst macro not defined), or continue per Configuration (macro defined).
- HOLD: ignore `sck`; `miso`=0.
- LOCK: entered when `reset` is released while `nss` is low. Wait for `nss` high, then → IDLE. This prevents adopting a frame mid-stream.
- Any state: `nss` rising edge → IDLE. If the bit counter is nonzero in HDR or DATA, pulse `frame_err`. `read_n`/`write_n` are never asserted on an incomplete word.

**Output rules.**
- `miso_oe` = 1 only in RD_WAIT/DATA/HOLD of a read frame; otherwise `miso`=0 and `miso_oe`=0.
- `address_bus` and `wdata` hold their values until the next update; they are not cleared on `nss` high.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `address_bus`=0, `wdata`=0, `read_n`=1, `write_n`=1, `busy`=0, `frame_err`=0. State = IDLE, or LOCK if `nss` is low.
- Pin-to-detect latency: 3 clk.
- Strobe timing: `read_n`/`write_n` go low on the clk after the detected last rising edge, and stay low for exactly 1 clk.
- Read-path budget: detect (3) + strobe (1) + `RD_LAT` (≤4) + load (1) ≤ 9 clk. This is less than one `sck` low half-period at 16× oversampling (8 clk) plus the high half, so `miso` MSB is valid before the first data rising edge.
- `sck` edges while `nss` is high are ignored.
- `nss` rising in the same clk as the last data rising edge: the word completes and its strobe fires, then → IDLE with no `frame_err`.

## Configuration
- `SPI_BUS_BRIDGE_BURST_EN` defined:
  - after each data word, `address_bus` increments (wrapping `2^ADDR_W-1` → 0) and the FSM stays in DATA;
  - writes: a `write_n` strobe per word;
  - reads: the next `read_n` is issued at the increment and RD_WAIT is re-entered;
  - this continues until `nss` rises.
- Not defined: exactly one data word per frame, then HOLD.

## Structure
- Package `spi_bus_bridge_pkg` contains:
  - the state enum (IDLE, HDR, RD_WAIT, DATA, HOLD, LOCK);
  - `SYNC_STAGES`=2;
  - the bit-counter width function `$clog2(max(ADDR_W+1, DATA_W)+1)`.
- One sub-module, `spi_sync`: 2-FF synchroniser plus rise/fall edge detector, instantiated for `sck`, `nss` and `mosi` (no edge outputs used for `mosi`).

## Test plan
- Write 0x01 then 0xF3 (defaults): `address_bus`=0x01, `wdata`=0xF3, one `write_n` pulse, `read_n` stays 1, `miso_oe`=0.
- Read 0x85 with `rdata`=0xAA, `RD_LAT`=3: one `read_n` pulse, `address_bus`=0x05, `miso` sequence 1,0,1,0,1,0,1,0 sampled on the second byte's rising edges.
- With the burst macro defined, write to 0x7F with 3 data words: writes at 0x7F, 0x00, 0x01; 3 `write_n` pulses. Without the macro: 1 pulse, words 2–3 ignored.
- `nss` raised after 5 data bits: `frame_err` pulse, no `write_n`; a following good frame works normally.
- `reset` pulsed mid-frame: all outputs return to reset values; remaining `sck` edges are ignored until `nss` goes high; the next frame decodes correctly.
- `ADDR_W`=10, `DATA_W`=16: an 11-bit header read of 0x2A5 followed by 16 `miso` bits matching `rdata`=0xBEEF.

Source files
------------

// File: rtl/spi_bus_bridge_pkg.sv
// spi_bus_bridge_pkg
//   Shared definitions for the SPI-to-parallel-bus bridge:
//   - state_t     : bridge FSM states
//   - SYNC_STAGES : depth of the input synchronisers
//   - cnt_width() : bit-counter width able to count the longer of header/data
package spi_bus_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_WAIT,
        DATA,
        HOLD,
        LOCK
    } state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int cnt_width(input int hdr_bits, input int data_bits);
        int m;
        m = (hdr_bits > data_bits) ? hdr_bits : data_bits;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_bus_bridge_if.sv
// spi_bus_bridge_if
//   SPI pins plus parallel-bus signals of the bridge.
//   slave  modport : the bridge (samples nss/sck/mosi/rdata, drives the rest)
//   master modport : the environment (SPI host + bus peripheral)
interface spi_bus_bridge_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              nss;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] address_bus;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              read_n;
    logic              write_n;
    logic              busy;
    logic              frame_err;

    modport slave (
        input  nss, sck, mosi, rdata,
        output miso, miso_oe, address_bus, wdata, read_n, write_n, busy, frame_err
    );

    modport master (
        output nss, sck, mosi, rdata,
        input  miso, miso_oe, address_bus, wdata, read_n, write_n, busy, frame_err
    );
endinterface

// File: rtl/spi_bus_bridge_sync.sv
// spi_sync
//   SYNC_STAGES-deep synchroniser with rise/fall detection on the
//   synchronised copy.
//   Ports: clk, reset (async, active-high), i_d (async input),
//          o_q (synchronised level), o_rise / o_fall (1-clk edge pulses).
//   All flops reset to 0; for nss this means "treat as selected" until the
//   real level arrives, which is what steers the bridge through LOCK.
module spi_sync
    import spi_bus_bridge_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise =  o_q & ~r_prev;
    assign o_fall = ~o_q &  r_prev;
endmodule

// File: rtl/spi_bus_bridge.sv
// spi_bus_bridge
//   SPI mode-0 slave that turns frames {rw, address, data} (MSB first) into
//   parallel-bus read/write cycles, fully synchronous to clk.
//   Parameters: ADDR_W (address width), DATA_W (data width, >= 4),
//               RD_LAT (clk cycles from read_n low to valid rdata, 1..4).
//   Ports: clk, reset (async, active-high), bus (spi_bus_bridge_if.slave).
//   Optional: define SPI_BUS_BRIDGE_BURST_EN for auto-increment bursts
//   (one bus cycle per data word until nss rises); default is one word
//   per frame followed by HOLD.
module spi_bus_bridge
    import spi_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    spi_bus_bridge_if.slave   bus
);
    localparam int HDR_W = ADDR_W + 1;
    localparam int SH_W  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int CNT_W = cnt_width(HDR_W, DATA_W);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    logic w_sck_rise, w_sck_fall, w_sck_unused;
    logic w_nss, w_nss_rise, w_nss_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync u_sync_sck  (.clk(clk), .reset(reset), .i_d(bus.sck),
                          .o_q(w_sck_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
    spi_sync u_sync_nss  (.clk(clk), .reset(reset), .i_d(bus.nss),
                          .o_q(w_nss), .o_rise(w_nss_rise), .o_fall(w_nss_fall));
    spi_sync u_sync_mosi (.clk(clk), .reset(reset), .i_d(bus.mosi),
                          .o_q(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused));

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [LAT_W-1:0]    r_lat;
    logic [SH_W-2:0]     r_rx;
    logic [DATA_W-1:0]   r_tx;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_miso, r_oe, r_read_n, r_write_n, r_busy, r_ferr;

    logic [SH_W-1:0]     w_rx_next;
    logic                w_word_done;

    assign w_rx_next   = {r_rx, w_mosi};
    assign w_word_done = (r_state == DATA) && w_sck_rise && (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Always restart in LOCK: it falls through to IDLE as soon as the
            // synchronised nss is seen high, so a frame already in flight is
            // never adopted half-way.
            r_state   <= LOCK;
            r_cnt     <= '0;
            r_lat     <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_miso    <= 1'b0;
            r_oe      <= 1'b0;
            r_read_n  <= 1'b1;
            r_write_n <= 1'b1;
            r_busy    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_read_n  <= 1'b1;
            r_write_n <= 1'b1;
            r_ferr    <= 1'b0;
            case (r_state)
                IDLE: if (w_nss_fall) begin
                    r_state <= HDR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
                HDR: if (w_sck_rise) begin
                    r_rx <= w_rx_next[SH_W-2:0];
                    if (r_cnt == CNT_W'(HDR_W - 1)) begin
                        r_cnt  <= '0;
                        r_rw   <= w_rx_next[ADDR_W];
                        r_addr <= w_rx_next[ADDR_W-1:0];
                        if (w_rx_next[ADDR_W]) begin
                            r_read_n <= 1'b0;
                            r_lat    <= '0;
                            r_oe     <= 1'b1;
                            r_state  <= RD_WAIT;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RD_WAIT: begin
                    // r_lat counts the clocks since read_n went low; rdata is
                    // captured on the clock after it is guaranteed valid.
                    if (r_lat == LAT_W'(RD_LAT)) begin
                        r_tx    <= bus.rdata;
                        r_state <= DATA;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                DATA: begin
                    if (w_sck_fall && r_rw) begin
                        r_miso <= r_tx[DATA_W-1];
                        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                    end
                    if (w_sck_rise) begin
                        r_rx <= w_rx_next[SH_W-2:0];
                        if (w_word_done) begin
                            r_cnt <= '0;
                            if (!r_rw) begin
                                r_wdata   <= w_rx_next[DATA_W-1:0];
                                r_write_n <= 1'b0;
                            end
`ifdef SPI_BUS_BRIDGE_BURST_EN
                            r_addr <= r_addr + 1'b1;
                            if (r_rw) begin
                                r_read_n <= 1'b0;
                                r_lat    <= '0;
                                r_state  <= RD_WAIT;
                            end
`else
                            r_miso  <= 1'b0;
                            r_state <= HOLD;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: r_miso <= 1'b0;
                LOCK: if (w_nss) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Deselect wins over everything above except a word that completes
            // on this very clock: its write strobe still goes out. A read
            // strobe would fetch a word nobody clocks out, so it is dropped.
            if (w_nss_rise) begin
                r_state  <= IDLE;
                r_busy   <= 1'b0;
                r_miso   <= 1'b0;
                r_oe     <= 1'b0;
                r_read_n <= 1'b1;
                if ((r_state == HDR || r_state == DATA) && r_cnt != '0 && !w_word_done)
                    r_ferr <= 1'b1;
            end
        end
    end

    assign bus.miso        = r_miso;
    assign bus.miso_oe     = r_oe;
    assign bus.address_bus = r_addr;
    assign bus.wdata       = r_wdata;
    assign bus.read_n      = r_read_n;
    assign bus.write_n     = r_write_n;
    assign bus.busy        = r_busy;
    assign bus.frame_err   = r_ferr;
endmodule
